// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: the arbiter FSM state
// encoding, the owner encoding used on the `owner` output, and the default
// datapath and statistics-counter widths.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // Owner encoding as seen on the `owner` output.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Default widths.
  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_CNT_W     = 16;

endpackage : mem_arb_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones instead of wrapping. Used for the
// per-side grant statistics of the memory port arbiter.
//
// Ports:
//   clk      in   clock, all updates on posedge
//   reset_n  in   synchronous active-low reset, clears the count
//   inc      in   count one event this cycle
//   count    out  current count (CNT_W bits), holds at all-ones once reached
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported main memory between the I-cache fill path and the
// D-cache fill/writeback path. One request is accepted in IDLE, its command is
// latched and driven to memory in ACCESS until mem_ready, then the winner gets
// a one-cycle done pulse (with read data for reads) in DONE.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : ties are decided by a last_winner register (reset = I); the
//               side that did not win last time is granted.
//   undefined : fixed D-over-I priority on ties.
//
// Ports:
//   clk, reset_n              clock and synchronous active-low reset
//   i_req, i_addr             I-side read request (held until i_done)
//   i_rdata, i_done           I-side read data and completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                   D-side request (held until d_done)
//   d_rdata, d_done           D-side read data and completion pulse
//   mem_read, mem_write,
//   mem_addr, mem_wdata       registered memory command
//   mem_rdata, mem_ready      memory response, only honoured in ACCESS
//   busy                      high in ACCESS and DONE
//   owner                     current or last owner (0 = I, 1 = D)
//   i_grants, d_grants        saturating per-side accepted-request counts
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // I-side
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  // D-side
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  // Memory
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  // Status
  output logic                 busy,
  output logic                 owner,
  output logic [CNT_W-1:0]     i_grants,
  output logic [CNT_W-1:0]     d_grants
);

  arb_state_t           state_q;
  logic                 we_q;
  logic                 owner_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [WORD_SIZE-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;
  logic [WORD_SIZE-1:0] i_rdata_q;
  logic [WORD_SIZE-1:0] d_rdata_q;
  logic                 i_done_q;
  logic                 d_done_q;
  logic                 busy_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                 last_winner_q;
`endif

  // Acceptance decision for the current IDLE cycle.
  logic accept;
  logic grant_owner;
  logic inc_i;
  logic inc_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept      = 1'b0;
    grant_owner = OWNER_I;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      accept = 1'b1;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        // Grant the side that did not win last time.
        grant_owner = (last_winner_q == OWNER_I) ? OWNER_D : OWNER_I;
`else
        grant_owner = OWNER_D;
`endif
      end else begin
        grant_owner = d_req ? OWNER_D : OWNER_I;
      end
    end
  end

  assign inc_i = accept && (grant_owner == OWNER_I);
  assign inc_d = accept && (grant_owner == OWNER_D);

  // Single FSM block; every output below is a register.
  // NOTE: the reset is synchronous and clears every register here, including
  // the data-path registers, so outputs are deterministic right after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      owner_q       <= OWNER_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q <= OWNER_I;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // The I side only ever reads, so its command carries no data.
            if (grant_owner == OWNER_D) begin
              we_q        <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_read_q  <= ~d_we;
              mem_write_q <= d_we;
            end else begin
              we_q        <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              mem_read_q  <= 1'b1;
              mem_write_q <= 1'b0;
            end
            owner_q <= grant_owner;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner_q <= grant_owner;
`endif
          end
        end

        ACCESS: begin
          // Requester inputs are ignored; hold the command until mem_ready.
          if (mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q == OWNER_D) begin
              d_done_q <= 1'b1;
              if (!we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
            state_q <= DONE;
          end
        end

        DONE: begin
          // Requests are not sampled here: the requester gets one cycle to
          // drop or renew req before IDLE looks at it again.
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_i_grants (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_i),
    .count   (i_grants)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_d_grants (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc_d),
    .count   (d_grants)
  );

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule : mem_port_arbiter
